// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : MIPS fetch stage with PC, word-addressed instruction memory,
//            field split and IDLE/RUN/HALT issue control.
//            Optional opcode trap: FETCH_ILLEGAL_OP_TRAP_EN.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic              instr_valid,
    output logic              illegal_op
);

    localparam int         c_DEPTH = 2 ** ADDR_W;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_HALT  = 2'd2;

    // PC is kept as a word address so the two low bits are structurally zero
    logic [29:0] r_pcWord;
    logic [29:0] w_pcWordNext;
    logic [29:0] w_seqWord;
    logic [29:0] w_branchWord;
    logic [1:0]  r_state;
    logic [1:0]  w_stateNext;
    logic        r_instrValid;
    logic        r_illegalOp;
    logic        w_illegal;
    logic [31:0] r_imem [c_DEPTH];

    assign pc     = {r_pcWord, 2'b00};
    assign instr  = r_imem[r_pcWord[ADDR_W-1:0]];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    assign instr_valid = r_instrValid;
    assign illegal_op  = r_illegalOp;

    assign w_seqWord    = r_pcWord + 30'd1;
    assign w_branchWord = w_seqWord + {{14{imm[15]}}, imm};

`ifdef FETCH_ILLEGAL_OP_TRAP_EN
    always_comb begin
        w_illegal = 1'b0;
        if ((r_state == c_RUN) && !stall) begin
            case (opcode)
                6'b000000, 6'b100011, 6'b101011, 6'b000100: w_illegal = 1'b0;
                default:                                    w_illegal = 1'b1;
            endcase
        end
    end
`else
    assign w_illegal = 1'b0;
`endif

    // Halt and trap both freeze the PC on the current instruction
    always_comb begin
        w_stateNext  = r_state;
        w_pcWordNext = r_pcWord;
        case (r_state)
            c_IDLE: begin
                if (start) w_stateNext = c_RUN;
            end
            c_RUN: begin
                if (halt || w_illegal) begin
                    w_stateNext = c_HALT;
                end else if (!stall) begin
                    w_pcWordNext = branch_taken ? w_branchWord : w_seqWord;
                end
            end
            c_HALT: begin
                if (start) w_stateNext = c_RUN;
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_pcWord     <= RESET_PC[31:2];
            r_instrValid <= 1'b0;
            r_illegalOp  <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_pcWord     <= w_pcWordNext;
            r_instrValid <= (w_stateNext == c_RUN);
            if (w_illegal) r_illegalOp <= 1'b1;
        end
    end

    // Contents survive reset; read port is asynchronous
    always_ff @(posedge clk) begin
        if (imem_we) r_imem[imem_waddr] <= imem_wdata;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle MIPS datapath. It holds the program counter, owns a small word-addressed instruction memory, and presents the current instruction split into fields, with `opcode` feeding the Control decoder. It advances the PC sequentially or to a branch target, using the `branch_taken` result computed downstream from Control's `Branch` and the ALU zero flag. A start/halt state machine gates instruction issue.

## Interface
- `ADDR_W`, default 6: instruction-memory index width; depth is 2^ADDR_W words.
- `RESET_PC`, default 32'h0000_0000: PC value on reset; must be word aligned.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: IDLE→RUN request, one-cycle pulse.
- `halt` input 1: RUN→HALT request.
- `stall` input 1: hold PC; current instruction stays presented.
- `branch_taken` input 1: take branch for the presented instruction.
- `imem_we` input 1: instruction-memory write enable.
- `imem_waddr` input ADDR_W: write word index.
- `imem_wdata` input 32: write data.
- `pc` output 32: address of the presented instruction.
- `instr` output 32: `imem[pc[ADDR_W+1:2]]`.
- `opcode` output 6: instr[31:26].
- `rs` output 5: instr[25:21].
- `rt` output 5: instr[20:16].
- `rd` output 5: instr[15:11].
- `shamt` output 5: instr[10:6].
- `funct` output 6: instr[5:0].
- `imm` output 16: instr[15:0].
- `instr_valid` output 1: high only in RUN.
- `illegal_op` output 1: sticky trap flag (see Configuration).

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: PC held. `start`=1 → RUN.
- RUN: `halt`=1 → HALT, takes priority over PC update that cycle. Otherwise the PC updates as follows.
  - `stall`=1: PC holds.
  - `branch_taken`=1: PC ← pc + 4 + (sext(imm) << 2).
  - Otherwise: PC ← pc + 4.
- HALT: PC frozen. `start`=1 → RUN, resuming at the held PC. Only reset returns to IDLE.
- `stall` and `branch_taken` together: `stall` wins and the branch is not taken. Control re-decodes the same instruction next cycle.
- `start` in RUN is ignored. `start` and `halt` together in IDLE: `start` wins and `halt` is ignored.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Negative offsets wrap likewise.
- Memory indexing uses pc[ADDR_W+1:2] only. Addresses above depth alias; no fault.
- `pc[1:0]` is always 0.
- Memory write is synchronous and read is asynchronous. A write to the presented index changes `instr` after that edge, in the same cycle the write lands.
- Memory contents are undefined after power-up and are not cleared by reset.

## Timing
- Field outputs are combinational from `pc` and memory, so Control decodes in the same cycle.
- PC update latency is 1 clock: `branch_taken` in cycle n → target presented in cycle n+1.
- `instr_valid` is registered state: it rises the cycle after the `start` edge and falls the cycle after the `halt` edge.
- `rst_n` low, asynchronously and including mid-RUN:
  - `pc`=RESET_PC
  - state=IDLE
  - `instr_valid`=0
  - `illegal_op`=0
- Field outputs reflect `imem[RESET_PC]` during and after reset.

## Configuration
- Macro `FETCH_ILLEGAL_OP_TRAP_EN`.
- Defined: in RUN with `stall`=0, an `opcode` outside {6'b000000, 6'b100011, 6'b101011, 6'b000100} causes the following at the next edge.
  - `illegal_op` is set (sticky until reset).
  - State → HALT.
  - PC stays on the offending instruction.
  - `branch_taken` that cycle is ignored.
  - `illegal_op` can coincide with `halt`; HALT is entered once.
- Not defined: `illegal_op` is tied to 0 and all opcodes advance normally.

## Test plan
- Reset/start: write words 0..3 = 0x00000020, 0x8C000004, 0xAC000008, 0x10000002; `start` → `pc` = 0,4,8,12 on consecutive cycles; `opcode` = 0x00,0x23,0x2B,0x04; `instr_valid` rises one cycle after `start`.
- Branch: at pc=12 with `imm`=2 and `branch_taken`=1 → next `pc`=24. With `imm`=16'hFFFD → next `pc`=4.
- Stall priority: `stall`=1 with `branch_taken`=1 for 3 cycles → `pc` constant. On release with `branch_taken`=1 → target taken.
- Halt/resume: `halt` at pc=8 → `pc` frozen at 8 and `instr_valid`=0. `start` → resumes at 8, then 12.
- Async reset mid-RUN at pc=20: outputs go to `pc`=0, `instr_valid`=0 before the next edge; `start` with no new memory writes → fetch restarts at pc=0 with the previously loaded words.
- With the macro defined: word at index 2 = 0xFC000000 → `illegal_op`=1, HALT, `pc`=8. Without the macro: `pc` advances to 12.
